// File: rtl/hs_check_pkg.sv
// rtl/hs_check_pkg.sv - shared types and helpers for the valid/ready stability checker
package hs_check_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } hs_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_DROP    = 2'd1,
    ERR_DATA    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } hs_err_kind_e;

  localparam int unsigned POP_MAX_W = 64;

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      n += {31'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/hs_check_chan.sv
// rtl/hs_check_chan.sv - one channel's stall FSM and payload capture
// Optional stall timeout enabled by HS_CHECK_TIMEOUT_EN.
module hs_check_chan
  import hs_check_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              check_en,
  input  logic              valid,
  input  logic              ready,
  input  logic [DATA_W-1:0] data,
  output logic              viol,
  output logic [1:0]        kind
);

  hs_state_e         state_q, state_d;
  logic [DATA_W-1:0] cap_q, cap_d;
  hs_err_kind_e      kind_e;
  logic              stall;

`ifdef HS_CHECK_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] cnt_q, cnt_d, cnt_inc;
`else
  logic [31:0] timeout_unused;
  assign timeout_unused = 32'(TIMEOUT);
`endif

  assign stall = valid & ~ready;
  assign viol  = (kind_e != ERR_NONE);
  assign kind  = kind_e;

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    kind_e  = ERR_NONE;
`ifdef HS_CHECK_TIMEOUT_EN
    cnt_d   = '0;
    cnt_inc = cnt_q + 1'b1;
`endif
    if (!check_en) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      if (stall) begin
        state_d = PEND;
        cap_d   = data;
      end
    end else begin
      if (!valid) begin
        kind_e = ERR_DROP;
      end else if (data != cap_q) begin
        kind_e = ERR_DATA;
      end
`ifdef HS_CHECK_TIMEOUT_EN
      // Counter only runs on a clean stall; any DROP/DATA restarts it.
      if (stall && kind_e == ERR_NONE) begin
        if (cnt_inc == TO_W'(TIMEOUT)) begin
          kind_e = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
`endif
      // Recapture every stalled cycle so each payload change counts once.
      if (stall) begin
        state_d = PEND;
        cap_d   = data;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
    end
  end

`ifdef HS_CHECK_TIMEOUT_EN
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

endmodule

// File: rtl/hs_stability_checker.sv
// rtl/hs_stability_checker.sv - multi-channel valid/ready stability monitor top
// Optional stall timeout enabled by HS_CHECK_TIMEOUT_EN.
module hs_stability_checker
  import hs_check_pkg::*;
#(
  parameter  int NUM_CH  = 4,
  parameter  int DATA_W  = 32,
  parameter  int CNT_W   = 16,
  parameter  int TIMEOUT = 256,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic                     check_en,
  input  logic                     clr,
  input  logic [NUM_CH-1:0]        valid,
  input  logic [NUM_CH-1:0]        ready,
  input  logic [NUM_CH*DATA_W-1:0] data,
  output logic [NUM_CH-1:0]        err_pulse,
  output logic [NUM_CH-1:0]        err_sticky,
  output logic [CNT_W-1:0]         fail_count,
  output logic                     first_err_vld,
  output logic [CH_W-1:0]          first_err_ch,
  output logic [1:0]               first_err_kind
);

  localparam int SUM_W = CNT_W + $clog2(NUM_CH + 1);

  logic [NUM_CH-1:0] viol;
  logic [1:0]        kind [NUM_CH];

  logic [NUM_CH-1:0] pulse_q, sticky_q, sticky_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_base;
  logic [SUM_W-1:0]  sum;
  logic              fvld_q, fvld_d, fvld_base;
  logic [CH_W-1:0]   fch_q, fch_d;
  logic [1:0]        fkind_q, fkind_d;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    hs_check_chan #(
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
    ) u_chan (
      .clk      (clk),
      .aresetn  (aresetn),
      .check_en (check_en),
      .valid    (valid[gi]),
      .ready    (ready[gi]),
      .data     (data[gi*DATA_W +: DATA_W]),
      .viol     (viol[gi]),
      .kind     (kind[gi])
    );
  end

  // clr wipes the accumulated state first; this edge's violations land on top.
  always_comb begin
    sticky_d  = (clr ? '0 : sticky_q) | viol;
    cnt_base  = clr ? '0 : cnt_q;
    sum       = SUM_W'(cnt_base) + SUM_W'(popcount(POP_MAX_W'(viol)));
    cnt_d     = (sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    fvld_base = clr ? 1'b0 : fvld_q;
    fvld_d    = fvld_base;
    fch_d     = clr ? '0 : fch_q;
    fkind_d   = clr ? '0 : fkind_q;
    if (!fvld_base && (|viol)) begin
      fvld_d = 1'b1;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (viol[i]) begin
          fch_d   = CH_W'(i);
          fkind_d = kind[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      pulse_q  <= '0;
      sticky_q <= '0;
      cnt_q    <= '0;
      fvld_q   <= 1'b0;
      fch_q    <= '0;
      fkind_q  <= '0;
    end else begin
      pulse_q  <= viol;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      fvld_q   <= fvld_d;
      fch_q    <= fch_d;
      fkind_q  <= fkind_d;
    end
  end

  assign err_pulse      = pulse_q;
  assign err_sticky     = sticky_q;
  assign fail_count     = cnt_q;
  assign first_err_vld  = fvld_q;
  assign first_err_ch   = fch_q;
  assign first_err_kind = fkind_q;

endmodule

// File: tb/tb_hs_stability_checker.sv
// tb/tb_hs_stability_checker.sv - directed plus randomized check against a behavioural model
module tb_hs_stability_checker;

  localparam int NUM_CH  = 4;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 16;
  localparam int CNT_S_W = 2;
  localparam int TIMEOUT = 4;
`ifdef HS_CHECK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     aresetn;
  logic                     check_en;
  logic                     clr;
  logic [NUM_CH-1:0]        valid;
  logic [NUM_CH-1:0]        ready;
  logic [NUM_CH*DATA_W-1:0] data;

  logic [NUM_CH-1:0] err_pulse, err_sticky, s_err_pulse, s_err_sticky;
  logic [CNT_W-1:0]  fail_count;
  logic [CNT_S_W-1:0] s_fail_count;
  logic              first_err_vld, s_first_err_vld;
  logic [1:0]        first_err_ch, s_first_err_ch;
  logic [1:0]        first_err_kind, s_first_err_kind;

  always #5 clk = ~clk;

  hs_stability_checker #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .aresetn(aresetn), .check_en(check_en), .clr(clr),
    .valid(valid), .ready(ready), .data(data),
    .err_pulse(err_pulse), .err_sticky(err_sticky), .fail_count(fail_count),
    .first_err_vld(first_err_vld), .first_err_ch(first_err_ch),
    .first_err_kind(first_err_kind)
  );

  hs_stability_checker #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_S_W), .TIMEOUT(TIMEOUT)
  ) dut_s (
    .clk(clk), .aresetn(aresetn), .check_en(check_en), .clr(clr),
    .valid(valid), .ready(ready), .data(data),
    .err_pulse(s_err_pulse), .err_sticky(s_err_sticky), .fail_count(s_fail_count),
    .first_err_vld(s_first_err_vld), .first_err_ch(s_first_err_ch),
    .first_err_kind(s_first_err_kind)
  );

  // Reference model: per-channel "waiting for ready" flag, held payload, stall length.
  bit          m_pend  [NUM_CH];
  logic [31:0] m_cap   [NUM_CH];
  int          m_cnt   [NUM_CH];
  logic [3:0]  m_pulse, m_sticky;
  int          m_total;
  bit          m_fvld;
  int          m_fch, m_fkind;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_pend[i] = 1'b0; m_cap[i] = '0; m_cnt[i] = 0;
    end
    m_pulse = '0; m_sticky = '0; m_total = 0;
    m_fvld = 1'b0; m_fch = 0; m_fkind = 0;
  endtask

  task automatic model_edge();
    int kd [NUM_CH];
    bit vi, ri, stalled;
    logic [31:0] di;
    int nviol;
    for (int i = 0; i < NUM_CH; i++) begin
      kd[i] = 0;
      vi = valid[i]; ri = ready[i]; di = data[i*DATA_W +: DATA_W];
      stalled = vi && !ri;
      if (!check_en) begin
        m_pend[i] = 1'b0; m_cnt[i] = 0;
      end else if (m_pend[i]) begin
        if (!vi) kd[i] = 1;
        else if (di != m_cap[i]) kd[i] = 2;
        else if (TO_EN && stalled) begin
          m_cnt[i]++;
          if (m_cnt[i] == TIMEOUT) begin
            kd[i] = 3; m_cnt[i] = 0;
          end
        end
        if (kd[i] == 1 || kd[i] == 2 || !stalled) m_cnt[i] = 0;
        m_pend[i] = stalled;
        if (stalled) m_cap[i] = di;
      end else if (stalled) begin
        m_pend[i] = 1'b1; m_cap[i] = di; m_cnt[i] = 0;
      end
    end
    if (clr) begin
      m_sticky = '0; m_total = 0; m_fvld = 1'b0; m_fch = 0; m_fkind = 0;
    end
    nviol = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_pulse[i] = (kd[i] != 0);
      if (kd[i] != 0) begin
        nviol++;
        m_sticky[i] = 1'b1;
      end
    end
    m_total += nviol;
    if (!m_fvld && nviol > 0) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (kd[i] != 0) begin
          m_fch = i; m_fkind = kd[i];
        end
      end
      m_fvld = 1'b1;
    end
  endtask

  task automatic check_outputs(input string tag);
    int exp_cnt, exp_s;
    exp_cnt = (m_total > 65535) ? 65535 : m_total;
    exp_s   = (m_total > 3) ? 3 : m_total;
    chk({tag, ":pulse"},   32'(err_pulse),      32'(m_pulse));
    chk({tag, ":sticky"},  32'(err_sticky),     32'(m_sticky));
    chk({tag, ":count"},   32'(fail_count),     32'(exp_cnt));
    chk({tag, ":fvld"},    32'(first_err_vld),  32'(m_fvld));
    chk({tag, ":fch"},     32'(first_err_ch),   32'(m_fch));
    chk({tag, ":fkind"},   32'(first_err_kind), 32'(m_fkind));
    chk({tag, ":s_pulse"}, 32'(s_err_pulse),    32'(m_pulse));
    chk({tag, ":s_count"}, 32'(s_fail_count),   32'(exp_s));
    chk({tag, ":s_fch"},   32'(s_first_err_ch), 32'(m_fch));
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic set_ch(input int i, input bit v, input bit r, input logic [31:0] d);
    valid[i] = v;
    ready[i] = r;
    data[i*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    int np;
    aresetn = 1'b0; check_en = 1'b1; clr = 1'b0;
    valid = '0; ready = '0; data = '0;
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge clk);
    aresetn = 1'b1;

    // Ch0 stable stall then accept.
    set_ch(0, 1, 0, 5);
    repeat (3) tick("ch0_stall");
    set_ch(0, 1, 1, 5); tick("ch0_accept");
    set_ch(0, 0, 0, 0);
    chk("ch0_no_fail", 32'(fail_count), 32'd0);

    // Ch1 two payload changes during one stall.
    set_ch(1, 1, 0, 5); tick("ch1_cap");
    set_ch(1, 1, 0, 6); tick("ch1_d6");
    set_ch(1, 1, 0, 7); tick("ch1_d7");
    set_ch(1, 1, 1, 7); tick("ch1_accept");
    set_ch(1, 0, 0, 0);
    chk("ch1_count", 32'(fail_count), 32'd2);
    chk("ch1_fch", 32'(first_err_ch), 32'd1);
    chk("ch1_fkind", 32'(first_err_kind), 32'd2);

    // Ch2 DROP and ch3 DATA at the same edge.
    clr = 1'b1; tick("clr1"); clr = 1'b0;
    set_ch(2, 1, 0, 0); set_ch(3, 1, 0, 0); tick("ch23_cap");
    set_ch(2, 0, 0, 0); set_ch(3, 1, 0, 1); tick("ch23_viol");
    chk("ch23_count", 32'(fail_count), 32'd2);
    chk("ch23_fch", 32'(first_err_ch), 32'd2);
    chk("ch23_sticky", 32'(err_sticky), 32'hc);
    set_ch(3, 1, 1, 1); tick("ch3_accept");
    set_ch(3, 0, 0, 0);

    // Disable mid-stall hides payload changes; re-enable starts fresh.
    set_ch(0, 1, 0, 1); tick("dis_cap");
    check_en = 1'b0;
    set_ch(0, 1, 0, 2); tick("dis_d2");
    set_ch(0, 1, 0, 3); tick("dis_d3");
    check_en = 1'b1; tick("reen");
    set_ch(0, 1, 1, 3); tick("reen_accept");
    set_ch(0, 0, 0, 0);
    chk("dis_hold", 32'(fail_count), 32'd2);

    // clr with a same-edge violation, then saturation of the narrow counter.
    set_ch(1, 1, 0, 9); tick("clr_cap");
    clr = 1'b1; set_ch(1, 1, 0, 10); tick("clr_viol"); clr = 1'b0;
    chk("clr_count", 32'(fail_count), 32'd1);
    for (int k = 0; k < 5; k++) begin
      set_ch(1, 1, 0, 32'(11 + k)); tick("sat");
    end
    chk("sat_s", 32'(s_fail_count), 32'd3);
    set_ch(1, 1, 1, 15); tick("sat_accept");
    set_ch(1, 0, 0, 0);

    // Asynchronous reset in the middle of a stall.
    set_ch(0, 1, 0, 7); tick("rst_cap");
    #2 aresetn = 1'b0;
    #1 model_reset();
    check_outputs("async_rst");
    chk("async_rst_count", 32'(fail_count), 32'd0);
    @(negedge clk);
    aresetn = 1'b1;
    tick("rst_resume");
    set_ch(0, 1, 1, 7); tick("rst_accept");
    set_ch(0, 0, 0, 0);

    // Long stable stall: TIMEOUT pulses only when the feature is built.
    np = 0;
    set_ch(0, 1, 0, 42);
    for (int k = 0; k < 9; k++) begin
      tick("to_stall");
      np += int'(err_pulse[0]);
    end
    chk("to_pulses", 32'(np), TO_EN ? 32'd2 : 32'd0);
    set_ch(0, 1, 1, 42); tick("to_accept");
    set_ch(0, 0, 0, 0); tick("to_idle");

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      check_en = ($urandom_range(0, 15) != 0);
      clr      = ($urandom_range(0, 31) == 0);
      for (int i = 0; i < NUM_CH; i++) begin
        set_ch(i, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
               32'($urandom_range(0, 2)));
      end
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
